group_router: RTL and testbench
===============================

Name: group_router

Overview:
- Leaf/group router directly downstream of the per-GPU network interfaces in one 4-GPU group.
- Accepts 16-bit flits from 4 leaf NIs and one uplink port, buffers each input in a small FIFO, and routes on the 6-bit header in bits [15:10] (4-bit group, 2-bit leaf).
- Flits for this group go to a leaf port; all other flits go to the uplink. Each output has its own round-robin arbiter.

Parameters:
- GROUP_ID, 7, 4-bit group number this router owns (header[15:12]).
- DATA_W, 16, flit width.
- HEADER_W, 6, header width: group [15:12], leaf [11:10].
- FIFO_DEPTH, 4, entries per input FIFO (power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- leaf_in_data  in  4*DATA_W  flit from NI leaf k at bits [k*16+:16].
- leaf_in_valid  in  4  per-leaf flit valid.
- leaf_in_ready  out  4  per-leaf: input FIFO not full.
- leaf_out_data  out  4*DATA_W  flit to NI leaf k.
- leaf_out_valid  out  4  per-leaf one-cycle valid pulse (no backpressure).
- up_in_data  in  DATA_W  flit from the parent router.
- up_in_valid  in  1  uplink flit valid.
- up_in_ready  out  1  uplink input FIFO not full.
- up_out_data  out  DATA_W  flit to the parent router.
- up_out_valid  out  1  uplink output valid.
- up_out_ready  in  1  parent accepts.
- drop_count  out  8  saturating count of dropped flits.

Behaviour:
- Reset: all FIFOs empty; all *_out_data = 0; leaf_out_valid = 0; up_out_valid = 0; drop_count = 0; all arbiter pointers = 0. Ready outputs are high right after reset, because they derive combinationally from FIFO state.
- Input indices: 0..3 are leaves, 4 is the uplink.
- Handshake: a flit is accepted when in_valid && in_ready. in_ready = !full, and it does not depend on whether a pop happens in the same cycle.
- Drop rules, applied at accept time. A dropped flit is accepted but never written to the FIFO, and drop_count increments, saturating at 255.
  - Header == 6'b000000, from any input.
  - Uplink input whose header group != GROUP_ID.
- Routing of a FIFO head:
  - header[15:12] == GROUP_ID → leaf output header[11:10]. Hairpin, leaf k to leaf k, is legal.
  - Otherwise → uplink output.
  - A flit arriving on the uplink input can never be routed back to the uplink.
- Arbitration: each output grants at most one input per cycle.
  - Round-robin over requesting inputs, starting at pointer p and searching p, p+1, … mod 5.
  - On a grant, p ← granted+1 mod 5. With no grant, p is unchanged.
  - Each head targets exactly one output, so there are no cross-output conflicts.
- Leaf output, on grant: leaf_out_data ← head; leaf_out_valid ← 1 for that cycle; the head is popped. Otherwise leaf_out_valid ← 0 and leaf_out_data holds its value.
- Uplink output:
  - If up_out_valid && !up_out_ready: hold data and valid; the uplink arbiter grants nothing.
  - Else, on grant: load data, valid ← 1, pop.
  - Else: valid ← 0.
- Latency: accept in cycle N, FIFO head visible in N+1, registered output valid in N+2. Minimum latency is 2 cycles; throughput is 1 flit/cycle per output.
- Simultaneous push and pop on the same FIFO: the count is unchanged and both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits, so full = (count == FIFO_DEPTH) is representable.
- Reset asserted mid-operation: all state clears immediately and in-flight flits are lost.

Decomposition:
- Package noc_pkg:
  - DATA_W, HEADER_W, NUM_LEAF = 4, NUM_PORTS = 5, UPLINK_IDX = 4.
  - Header field slice constants (GRP_MSB = 15, GRP_LSB = 12, LEAF_MSB = 11, LEAF_LSB = 10).
  - Invalid-header constant 6'b000000.
- Sub-module noc_flit_fifo: one parameterised FIFO with push, pop, head, full, empty; instantiated 5 times.
- Routing decode and round-robin arbiters stay inline.

Test Plan:
- Leaf 1 sends 0x7005 (group 7, leaf 0) at cycle N → leaf_out_valid[0] = 1 at N+2 with leaf_out_data[15:0] = 0x7005; drop_count stays 0.
- Leaf 0 sends 0x1003 (group 1) → up_out_valid = 1 with up_out_data = 0x1003. Hold up_out_ready = 0 for 3 cycles → data and valid stay stable; the flit leaves on the first ready cycle.
- Leaves 0, 1, 2 and the uplink all send flits to leaf 3 (0x7C00 | src index) every cycle for 8 cycles → leaf 3 output order follows round-robin starting at input 0 (0, 1, 2, 4, 0, 1, …); no flit is lost or duplicated.
- up_out_ready held at 0 while leaf 2 streams 6 uplink-bound flits (0x2000–0x2005) → leaf_in_ready[2] drops to 0 after FIFO_DEPTH accepted plus 1 in the output register. After ready is released, all 6 emerge in order.
- Uplink input 0x3001 (wrong group) and leaf input 0x0000 → both are accepted, neither appears on any output, drop_count = 2.
- With several flits buffered, assert reset for 1 cycle → all valids are 0, drop_count = 0, and all in_ready = 1 immediately. A subsequent flit 0x7405 reaches leaf 1 with latency 2.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants, types and round-robin helpers for the group router.
package noc_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned HEADER_W   = 6;
    localparam int unsigned NUM_LEAF   = 4;
    localparam int unsigned NUM_PORTS  = 5;
    localparam int unsigned UPLINK_IDX = 4;

    localparam int unsigned GRP_MSB  = 15;
    localparam int unsigned GRP_LSB  = 12;
    localparam int unsigned LEAF_MSB = 11;
    localparam int unsigned LEAF_LSB = 10;

    localparam logic [HEADER_W-1:0] HDR_INVALID = '0;

    typedef logic [DATA_W-1:0] flit_t;
    typedef logic [2:0]        port_idx_t;

    typedef struct packed {
        logic      found;
        port_idx_t idx;
    } grant_t;

    // First requester at or after ptr, searching cyclically over all ports.
    function automatic grant_t rr_pick(input logic [NUM_PORTS-1:0] req, input port_idx_t ptr);
        grant_t      g;
        int unsigned i;
        g = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            i = (32'(ptr) + j) % NUM_PORTS;
            if (!g.found && req[i]) begin
                g.found = 1'b1;
                g.idx   = port_idx_t'(i);
            end
        end
        return g;
    endfunction

    function automatic port_idx_t rr_next(input port_idx_t idx);
        return (idx == port_idx_t'(UPLINK_IDX)) ? '0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/group_router_if.sv
// Flit bus between the group router and its four leaf NIs plus the parent router.
interface group_router_if;
    import noc_pkg::*;

    logic [NUM_LEAF*DATA_W-1:0] leaf_in_data;
    logic [NUM_LEAF-1:0]        leaf_in_valid;
    logic [NUM_LEAF-1:0]        leaf_in_ready;
    logic [NUM_LEAF*DATA_W-1:0] leaf_out_data;
    logic [NUM_LEAF-1:0]        leaf_out_valid;
    logic [DATA_W-1:0]          up_in_data;
    logic                       up_in_valid;
    logic                       up_in_ready;
    logic [DATA_W-1:0]          up_out_data;
    logic                       up_out_valid;
    logic                       up_out_ready;
    logic [7:0]                 drop_count;

    modport slave (
        input  leaf_in_data, leaf_in_valid, up_in_data, up_in_valid, up_out_ready,
        output leaf_in_ready, leaf_out_data, leaf_out_valid, up_in_ready,
               up_out_data, up_out_valid, drop_count
    );

    modport master (
        output leaf_in_data, leaf_in_valid, up_in_data, up_in_valid, up_out_ready,
        input  leaf_in_ready, leaf_out_data, leaf_out_valid, up_in_ready,
               up_out_data, up_out_valid, drop_count
    );

endinterface

// File: rtl/noc_flit_fifo.sv
// Per-input flit FIFO with a combinational head; caller guarantees no push when full / pop when empty.
module noc_flit_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/group_router.sv
// Group router: five buffered inputs (4 leaves + uplink) routed on the header to
// four leaf outputs and one backpressured uplink output, each with a round-robin arbiter.
module group_router
    import noc_pkg::*;
#(
    parameter logic [3:0]  GROUP_ID   = 4'd7,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    group_router_if.slave  bus
);

    flit_t                in_data [NUM_PORTS];
    flit_t                head    [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_valid, full, empty, push, pop, drop;
    port_idx_t            tgt     [NUM_PORTS];
    logic [NUM_PORTS-1:0] req     [NUM_PORTS];
    grant_t               gnt     [NUM_PORTS];
    logic                 up_stall;

    port_idx_t            ptr_q [NUM_PORTS], ptr_d [NUM_PORTS];
    flit_t                leaf_data_q [NUM_LEAF], leaf_data_d [NUM_LEAF];
    logic [NUM_LEAF-1:0]  leaf_valid_q, leaf_valid_d;
    flit_t                up_data_q, up_data_d;
    logic                 up_valid_q, up_valid_d;
    logic [7:0]           drop_q, drop_d;
    logic [8:0]           drop_sum;
    logic [NUM_LEAF*DATA_W-1:0] leaf_out_pack;

    always_comb begin
        for (int unsigned i = 0; i < NUM_LEAF; i++) in_data[i] = bus.leaf_in_data[i*DATA_W +: DATA_W];
        in_data[UPLINK_IDX] = bus.up_in_data;
        in_valid = {bus.up_in_valid, bus.leaf_in_valid};
    end

    // Dropped flits are still accepted (handshake completes) but never stored.
    always_comb begin
        push = '0;
        drop = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (in_valid[i] && !full[i]) begin
                if (in_data[i][GRP_MSB:LEAF_LSB] == HDR_INVALID ||
                    (i == UPLINK_IDX && in_data[i][GRP_MSB:GRP_LSB] != GROUP_ID))
                    drop[i] = 1'b1;
                else
                    push[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        noc_flit_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push[g]),
            .data_i  (in_data[g]),
            .pop_i   (pop[g]),
            .head_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
    end

    always_comb begin
        up_stall = up_valid_q && !bus.up_out_ready;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            tgt[i] = (head[i][GRP_MSB:GRP_LSB] == GROUP_ID) ? port_idx_t'(head[i][LEAF_MSB:LEAF_LSB])
                                                          : port_idx_t'(UPLINK_IDX);
        end
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                req[o][i] = !empty[i] && (tgt[i] == port_idx_t'(o));
            end
        end
        if (up_stall) req[UPLINK_IDX] = '0;
        pop = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            gnt[o] = rr_pick(req[o], ptr_q[o]);
            if (gnt[o].found) pop[gnt[o].idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        leaf_data_d  = leaf_data_q;
        leaf_valid_d = '0;
        up_data_d    = up_data_q;
        up_valid_d   = up_valid_q;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (gnt[o].found) ptr_d[o] = rr_next(gnt[o].idx);
        end
        for (int unsigned o = 0; o < NUM_LEAF; o++) begin
            if (gnt[o].found) begin
                leaf_data_d[o]  = head[gnt[o].idx];
                leaf_valid_d[o] = 1'b1;
            end
        end
        if (!up_stall) begin
            up_valid_d = gnt[UPLINK_IDX].found;
            if (gnt[UPLINK_IDX].found) up_data_d = head[gnt[UPLINK_IDX].idx];
        end
        drop_sum = {1'b0, drop_q};
        for (int unsigned i = 0; i < NUM_PORTS; i++) drop_sum = drop_sum + 9'(drop[i]);
        drop_d = drop_sum[8] ? '1 : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '{default: '0};
            leaf_data_q  <= '{default: '0};
            leaf_valid_q <= '0;
            up_data_q    <= '0;
            up_valid_q   <= 1'b0;
            drop_q       <= '0;
        end else begin
            ptr_q        <= ptr_d;
            leaf_data_q  <= leaf_data_d;
            leaf_valid_q <= leaf_valid_d;
            up_data_q    <= up_data_d;
            up_valid_q   <= up_valid_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        leaf_out_pack = '0;
        for (int unsigned o = 0; o < NUM_LEAF; o++) leaf_out_pack[o*DATA_W +: DATA_W] = leaf_data_q[o];
    end

    assign bus.leaf_in_ready  = ~full[NUM_LEAF-1:0];
    assign bus.up_in_ready    = ~full[UPLINK_IDX];
    assign bus.leaf_out_data  = leaf_out_pack;
    assign bus.leaf_out_valid = leaf_valid_q;
    assign bus.up_out_data    = up_data_q;
    assign bus.up_out_valid   = up_valid_q;
    assign bus.drop_count     = drop_q;

endmodule

// File: tb/tb_group_router.sv
// Randomised bench for group_router against a queue-based model, plus directed scenarios.
module tb_group_router;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    group_router_if bus();

    group_router #(.GROUP_ID(4'd7), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    // Behavioural model: one queue per input, pointer per output.
    logic [15:0] mq [5][$];
    int          mptr [5];
    logic [15:0] m_ld [4];
    logic [3:0]  m_lv;
    logic [15:0] m_ud;
    bit          m_uv;
    int          m_drop;
    int          push_cnt;
    logic [15:0] leaf_log [4][$];
    logic [15:0] up_log [$];

    function automatic int route(logic [15:0] f);
        return (f[15:12] == 4'd7) ? int'(f[11:10]) : 4;
    endfunction

    function automatic logic [15:0] in_data(int i);
        return (i < 4) ? bus.leaf_in_data[i*16 +: 16] : bus.up_in_data;
    endfunction

    function automatic bit in_valid(int i);
        return (i < 4) ? bus.leaf_in_valid[i] : bus.up_in_valid;
    endfunction

    function automatic bit m_ready(int i);
        return mq[i].size() < 4;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 5; i++) begin
            mq[i].delete();
            mptr[i] = 0;
        end
        for (int o = 0; o < 4; o++) m_ld[o] = '0;
        m_lv = '0; m_ud = '0; m_uv = 1'b0; m_drop = 0;
    endtask

    task automatic model_step();
        int          gi [5];
        bit          rdy [5];
        int          src;
        logic [15:0] f;
        for (int i = 0; i < 5; i++) rdy[i] = m_ready(i);
        for (int o = 0; o < 5; o++) begin
            gi[o] = -1;
            if (!(o == 4 && m_uv && !bus.up_out_ready)) begin
                for (int j = 0; j < 5; j++) begin
                    src = (mptr[o] + j) % 5;
                    if (gi[o] < 0 && mq[src].size() > 0 && route(mq[src][0]) == o) gi[o] = src;
                end
            end
        end
        for (int o = 0; o < 4; o++) begin
            m_lv[o] = (gi[o] >= 0);
            if (gi[o] >= 0) begin
                m_ld[o] = mq[gi[o]][0];
                mptr[o] = (gi[o] + 1) % 5;
            end
        end
        if (!(m_uv && !bus.up_out_ready)) begin
            m_uv = (gi[4] >= 0);
            if (gi[4] >= 0) begin
                m_ud    = mq[gi[4]][0];
                mptr[4] = (gi[4] + 1) % 5;
            end
        end
        for (int o = 0; o < 5; o++) if (gi[o] >= 0) void'(mq[gi[o]].pop_front());
        for (int i = 0; i < 5; i++) begin
            if (in_valid(i) && rdy[i]) begin
                f = in_data(i);
                if (f[15:10] == 6'd0 || (i == 4 && f[15:12] != 4'd7)) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    mq[i].push_back(f);
                    push_cnt++;
                end
            end
        end
    endtask

    // Pre-edge sampling: logs what the DUT presents, then advances the model.
    always @(posedge clk or posedge reset) begin
        if (reset) model_clear();
        else begin
            for (int o = 0; o < 4; o++)
                if (bus.leaf_out_valid[o]) leaf_log[o].push_back(bus.leaf_out_data[o*16 +: 16]);
            if (bus.up_out_valid && bus.up_out_ready) up_log.push_back(bus.up_out_data);
            model_step();
        end
    end

    always @(negedge clk) begin : cmp
        logic [63:0] exp_ld;
        logic [4:0]  exp_rdy;
        if (chk_en) begin
            exp_ld = '0;
            for (int o = 0; o < 4; o++) exp_ld[o*16 +: 16] = m_ld[o];
            for (int i = 0; i < 5; i++) exp_rdy[i] = m_ready(i);
            chk("leaf_out_valid", 64'(bus.leaf_out_valid), 64'(m_lv));
            chk("leaf_out_data", bus.leaf_out_data, exp_ld);
            chk("up_out_valid", 64'(bus.up_out_valid), 64'(m_uv));
            chk("up_out_data", 64'(bus.up_out_data), 64'(m_ud));
            chk("in_ready", 64'({bus.up_in_ready, bus.leaf_in_ready}), 64'(exp_rdy));
            chk("drop_count", 64'(bus.drop_count), 64'(m_drop));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.leaf_in_valid = '0;
        bus.leaf_in_data  = '0;
        bus.up_in_valid   = 1'b0;
        bus.up_in_data    = '0;
    endtask

    task automatic clear_logs();
        for (int o = 0; o < 4; o++) leaf_log[o].delete();
        up_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_logs();
        tick();
    endtask

    function automatic logic [15:0] rand_flit();
        int          r;
        logic [15:0] f;
        r = $urandom_range(0, 9);
        f = 16'($urandom);
        if (r < 6) f[15:12] = 4'd7;
        else if (r == 8) f[15:10] = 6'd0;
        return f;
    endfunction

    initial begin : main
        int n;
        bit acc;
        int tot;
        int rr_exp [4];
        rr_exp = '{0, 1, 2, 4};

        idle();
        bus.up_out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_leaf_valid", 64'(bus.leaf_out_valid), 64'h0);
        chk("rst_up_valid", 64'(bus.up_out_valid), 64'h0);
        chk("rst_drop", 64'(bus.drop_count), 64'h0);
        chk("rst_ready", 64'({bus.up_in_ready, bus.leaf_in_ready}), 64'h1F);
        chk("rst_leaf_data", bus.leaf_out_data, 64'h0);
        reset = 1'b0;
        chk_en = 1'b1;
        tick();

        // Local delivery leaf 1 -> leaf 0, latency 2.
        bus.leaf_in_data[16 +: 16] = 16'h7005;
        bus.leaf_in_valid[1] = 1'b1;
        tick();
        idle();
        tick();
        chk("t1_valid", 64'(bus.leaf_out_valid), 64'h1);
        chk("t1_data", 64'(bus.leaf_out_data[15:0]), 64'h7005);
        chk("t1_drop", 64'(bus.drop_count), 64'h0);

        // Uplink hold under backpressure.
        bus.up_out_ready = 1'b0;
        bus.leaf_in_data[15:0] = 16'h1003;
        bus.leaf_in_valid[0] = 1'b1;
        tick();
        idle();
        tick();
        chk("t2_valid", 64'(bus.up_out_valid), 64'h1);
        chk("t2_data", 64'(bus.up_out_data), 64'h1003);
        tick();
        tick();
        chk("t2_hold_valid", 64'(bus.up_out_valid), 64'h1);
        chk("t2_hold_data", 64'(bus.up_out_data), 64'h1003);
        bus.up_out_ready = 1'b1;
        up_log.delete();
        tick();
        chk("t2_log_size", 64'(up_log.size()), 64'd1);
        chk("t2_log_data", 64'(up_log.size() > 0 ? up_log[0] : 16'hDEAD), 64'h1003);
        chk("t2_after", 64'(bus.up_out_valid), 64'h0);

        // Four sources contend for leaf 3.
        tick();
        clear_logs();
        push_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 3; i++) bus.leaf_in_data[i*16 +: 16] = 16'h7C00 | 16'(i);
            bus.leaf_in_valid = 4'b0111;
            bus.up_in_data  = 16'h7C04;
            bus.up_in_valid = 1'b1;
            tick();
        end
        idle();
        repeat (40) tick();
        chk("rr_count", 64'(leaf_log[3].size()), 64'(push_cnt));
        for (int k = 0; k < 8; k++)
            chk("rr_order", 64'(k < leaf_log[3].size() ? leaf_log[3][k] : 16'hFFFF),
                64'(16'h7C00 | 16'(rr_exp[k % 4])));

        // Uplink stall fills leaf 2's FIFO plus the output register.
        bus.up_out_ready = 1'b0;
        up_log.delete();
        n = 0;
        for (int c = 0; c < 10; c++) begin
            acc = 1'b0;
            if (n < 6) begin
                bus.leaf_in_data[32 +: 16] = 16'h2000 + 16'(n);
                bus.leaf_in_valid[2] = 1'b1;
                acc = m_ready(2);
            end
            tick();
            if (acc) n++;
        end
        chk("bp_accepted", 64'(n), 64'd5);
        chk("bp_ready", 64'(bus.leaf_in_ready[2]), 64'h0);
        bus.up_out_ready = 1'b1;
        for (int c = 0; c < 20 && n < 6; c++) begin
            bus.leaf_in_data[32 +: 16] = 16'h2000 + 16'(n);
            bus.leaf_in_valid[2] = 1'b1;
            acc = m_ready(2);
            tick();
            if (acc) n++;
        end
        idle();
        chk("bp_all_sent", 64'(n), 64'd6);
        repeat (10) tick();
        chk("bp_log_size", 64'(up_log.size()), 64'd6);
        for (int k = 0; k < 6; k++)
            chk("bp_order", 64'(k < up_log.size() ? up_log[k] : 16'hFFFF), 64'(16'h2000 + 16'(k)));

        // Drops: wrong group on uplink, zero header on a leaf, same cycle.
        do_reset();
        bus.up_in_data  = 16'h3001;
        bus.up_in_valid = 1'b1;
        bus.leaf_in_data[15:0] = 16'h0000;
        bus.leaf_in_valid[0] = 1'b1;
        tick();
        idle();
        repeat (4) tick();
        chk("drop_count2", 64'(bus.drop_count), 64'd2);
        tot = up_log.size();
        for (int o = 0; o < 4; o++) tot += leaf_log[o].size();
        chk("drop_no_output", 64'(tot), 64'd0);

        // Reset mid-operation with flits buffered.
        bus.up_out_ready = 1'b0;
        bus.leaf_in_data  = {16'h0, 16'h0000, 16'h1222, 16'h1111};
        bus.leaf_in_valid = 4'b0111;
        repeat (3) tick();
        idle();
        reset = 1'b1;
        #1;
        chk("mid_rst_leaf_valid", 64'(bus.leaf_out_valid), 64'h0);
        chk("mid_rst_up_valid", 64'(bus.up_out_valid), 64'h0);
        chk("mid_rst_drop", 64'(bus.drop_count), 64'h0);
        chk("mid_rst_ready", 64'({bus.up_in_ready, bus.leaf_in_ready}), 64'h1F);
        tick();
        reset = 1'b0;
        bus.up_out_ready = 1'b1;
        clear_logs();
        tick();
        bus.leaf_in_data[15:0] = 16'h7405;
        bus.leaf_in_valid[0] = 1'b1;
        tick();
        idle();
        tick();
        chk("post_rst_valid", 64'(bus.leaf_out_valid), 64'h2);
        chk("post_rst_data", 64'(bus.leaf_out_data[31:16]), 64'h7405);

        // Random traffic.
        do_reset();
        repeat (3000) begin
            for (int i = 0; i < 4; i++) begin
                bus.leaf_in_valid[i] = ($urandom_range(0, 1) == 1);
                bus.leaf_in_data[i*16 +: 16] = rand_flit();
            end
            bus.up_in_valid  = ($urandom_range(0, 1) == 1);
            bus.up_in_data   = rand_flit();
            bus.up_out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle();
        bus.up_out_ready = 1'b1;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
